// File: rtl/serial_adder_if.sv
// Handshake bundle for serial_adder: operand input channel and result output channel.
// out_ovf exists only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             out_ovf;
`endif

    modport master (
        output in_valid, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout
`ifdef SERIAL_ADDER_OVF_EN
        , input out_ovf
`endif
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout
`ifdef SERIAL_ADDER_OVF_EN
        , output out_ovf
`endif
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a registered carry, LSB first.
// Optional signed-overflow output enabled by SERIAL_ADDER_OVF_EN.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic           sys_clk,
    input  logic           sys_rst,
    serial_adder_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] sa, sa_next;
    logic [WIDTH-1:0] sb, sb_next;
    logic [WIDTH-1:0] sum_reg, sum_reg_next;
    logic [WIDTH-1:0] sum_shift;
    logic             carry, carry_next;
    logic [CW-1:0]    cnt, cnt_next;
    logic [WIDTH-1:0] res_sum, res_sum_next;
    logic             res_cout, res_cout_next;
    logic             fa_s, fa_c;
`ifdef SERIAL_ADDER_OVF_EN
    logic             res_ovf, res_ovf_next;
`endif

    function automatic logic fa_sum(input logic a, input logic b, input logic c);
        return a ^ b ^ c;
    endfunction

    function automatic logic fa_count(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    assign fa_s      = fa_sum(sa[0], sb[0], carry);
    assign fa_c      = fa_count(sa[0], sb[0], carry);
    // New sum bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
    assign sum_shift = (sum_reg >> 1'b1) | (WIDTH'(fa_s) << (WIDTH - 1));

    // State register.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath next values.
    always_comb begin
        state_next    = state;
        sa_next       = sa;
        sb_next       = sb;
        sum_reg_next  = sum_reg;
        carry_next    = carry;
        cnt_next      = cnt;
        res_sum_next  = res_sum;
        res_cout_next = res_cout;
`ifdef SERIAL_ADDER_OVF_EN
        res_ovf_next  = res_ovf;
`endif
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    sa_next      = bus.in_a;
                    sb_next      = bus.in_b;
                    carry_next   = bus.in_cin;
                    cnt_next     = '0;
                    sum_reg_next = '0;
                    state_next   = RUN;
                end else begin
                    state_next   = IDLE;
                end
            end
            RUN: begin
                sa_next      = sa >> 1'b1;
                sb_next      = sb >> 1'b1;
                sum_reg_next = sum_shift;
                carry_next   = fa_c;
                cnt_next     = cnt + CNT_ONE;
                if (cnt == CNT_LAST) begin
                    res_sum_next  = sum_shift;
                    res_cout_next = fa_c;
`ifdef SERIAL_ADDER_OVF_EN
                    res_ovf_next  = carry ^ fa_c;
`endif
                    state_next    = DONE;
                end else begin
                    state_next    = RUN;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end else begin
                    state_next = DONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath and result registers.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sa       <= '0;
            sb       <= '0;
            sum_reg  <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            res_sum  <= '0;
            res_cout <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            res_ovf  <= 1'b0;
`endif
        end else begin
            sa       <= sa_next;
            sb       <= sb_next;
            sum_reg  <= sum_reg_next;
            carry    <= carry_next;
            cnt      <= cnt_next;
            res_sum  <= res_sum_next;
            res_cout <= res_cout_next;
`ifdef SERIAL_ADDER_OVF_EN
            res_ovf  <= res_ovf_next;
`endif
        end
    end

    // Handshake flags come from the state register; in_ready is held low during reset.
    assign bus.in_ready  = (state == IDLE) && !sys_rst;
    assign bus.out_valid = (state == DONE);
    assign bus.out_sum   = res_sum;
    assign bus.out_cout  = res_cout;
`ifdef SERIAL_ADDER_OVF_EN
    assign bus.out_ovf   = res_ovf;
`endif
endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit adder built around one full-adder cell (in1, in2, cin → sum, count) and a registered carry. It accepts a pair of operands plus carry-in over a valid/ready handshake, then processes one bit per clock, LSB first, feeding each `count` back as the next `cin`. It presents the WIDTH-bit sum and carry-out on a second valid/ready handshake. It sits directly upstream of and around the combinational full adder, turning it into a multi-bit sequential adder with low area.

## Interface
- `WIDTH`, default 8: operand and sum width in bits; legal range 1..32.
- `sys_clk`  in  1  system clock; all state updates on the rising edge.
- `sys_rst`  in  1  reset, asynchronous and active-high.
- `in_valid`  in  1  operand pair present.
- `in_ready`  out  1  block can accept operands.
- `in_a`  in  WIDTH  operand A.
- `in_b`  in  WIDTH  operand B.
- `in_cin`  in  1  carry-in for bit 0.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer takes result.
- `out_sum`  out  WIDTH  sum, bits [WIDTH-1:0].
- `out_cout`  out  1  carry-out of bit WIDTH-1.
- `out_ovf`  out  1  signed overflow; present only with SERIAL_ADDER_OVF_EN.

## Operation
- **FSM states:** IDLE, RUN, DONE.
- **Reset:**
  - Asynchronous; state goes to IDLE.
  - Shift registers, carry flop, bit counter, `out_sum`, `out_cout` and `out_ovf` clear to 0.
  - `out_valid` is 0.
  - `in_ready` is 0 while `sys_rst` is high and 1 after release.
- **IDLE:**
  - `in_ready` = 1.
  - On `in_valid` && `in_ready`: load A→sa and B→sb, set carry ← `in_cin`, set bit counter ← 0, clear sum register; go to RUN.
- **RUN:**
  - `in_ready` = 0.
  - Each cycle, the full adder computes sum = sa[0]^sb[0]^carry and count = majority(sa[0], sb[0], carry).
  - Sum bit shifts into sum-register MSB; sa and sb shift right; carry ← count; counter +1.
  - Counter is $clog2(WIDTH+1) bits.
  - On the cycle counter == WIDTH-1: latch the final sum into `out_sum` and count into `out_cout`; go to DONE.
  - With WIDTH = 1, RUN lasts exactly one cycle.
- **DONE:**
  - `out_valid` = 1.
  - `out_sum`, `out_cout` and `out_ovf` are held stable until `out_valid` && `out_ready`, then go to IDLE.
  - `in_valid` is ignored in DONE, even when `out_ready` is high in the same cycle; there is no bypass.
- **Arithmetic:** {`out_cout`, `out_sum`} = `in_a` + `in_b` + `in_cin`, modulo 2^(WIDTH+1); operands are unsigned.
- **Operand capture:** input operands are sampled only at acceptance; later changes on `in_a`, `in_b` and `in_cin` have no effect.
- **Reset mid-operation:** the operation is abandoned; no `out_valid` pulse is produced; the block returns to IDLE with all outputs cleared.
- **Result outputs:** `out_sum` and `out_cout` keep the last result after the handshake until the next result is latched.

## Timing
- Acceptance edge E0: IDLE → RUN.
- Bits are processed at edges E1..EWIDTH; `out_valid` goes high after EWIDTH.
- Latency from accept to `out_valid` is WIDTH cycles.
- With `out_ready` held high, the handshake completes at EWIDTH+1.
- `in_ready` rises after EWIDTH+1; the next accept is at EWIDTH+2 at the earliest.
- Peak throughput: one addition per WIDTH+2 cycles.
- `in_ready` and `out_valid` are decoded from registered state only; there is no combinational path from `in_valid` or `out_ready` to either.

## Configuration
- **Macro:** `SERIAL_ADDER_OVF_EN`.
- **When defined:**
  - The `out_ovf` port exists.
  - It is latched in RUN's last cycle as carry-into-MSB XOR carry-out, i.e. the two's-complement overflow of `in_a` + `in_b` + `in_cin`.
  - It resets to 0 and is held with `out_sum`.
- **When undefined:** the port and its logic are absent, and all other behaviour is identical.

## Test plan
- WIDTH=8, A=0x5A, B=0x3C, cin=0 → `out_sum`=0x96, `out_cout`=0, `out_ovf`=1; `out_valid` asserted exactly 8 cycles after accept.
- A=0xFF, B=0x01, cin=0 → `out_sum`=0x00, `out_cout`=1, `out_ovf`=0. Then A=0xFF, B=0xFF, cin=1 → `out_sum`=0xFF, `out_cout`=1, `out_ovf`=0.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE while `in_valid`=1 → `out_valid` stays 1, `out_sum` is stable, `in_ready`=0, and no new operand is accepted. Then release `out_ready` → next accept happens 2 cycles after release.
- Change `in_a` and `in_b` during RUN → result reflects only the operands captured at acceptance.
- Assert `sys_rst` after 3 bits of A=0x12, B=0x34 → all outputs become 0 immediately, with no `out_valid`. After release, 0x12+0x34 → 0x46, `cout`=0.
- 500 random operand/cin triples with random `out_ready` gaps, checked against a behavioural `+` model.
- Also run the same check with WIDTH=1 (1+1+1 → sum=1, `cout`=1, 1-cycle latency).
